gates_selftest_seq: RTL and testbench

Self-test sequencer for the two-input basic-gates block (OR, AND, XOR, NOR, NAND, XNOR outputs).
- On a start request it drives the gate inputs a/b through all four combinations in order 00, 01, 10, 11.
- It waits a programmable settle time, then compares the six gate outputs against the built-in truth table.
- It reports per-vector fail flags, a fail count, and an overall pass flag with a done pulse.
- It sits beside the gates instance on the FPGA board and replaces manual bench checking with an on-chip BIST.

---
 rtl/gates_selftest_seq.sv | 121 ++++++++++++
 tb/tb_gates_selftest_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gates_selftest_seq.sv
// On-chip self-test sequencer for the two-input basic-gates block.
// Walks {a,b} through 00..11, waits SETTLE_CYCLES, checks all six gate outputs.
module gates_selftest_seq #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [2:0] fail_count
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_vec;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_mask;
    logic [2:0]    r_count;
    logic          r_pass;
    logic [5:0]    w_exp;
    logic          w_miss;
    logic [3:0]    w_mask_nxt;

    // Truth table as {OR, AND, XOR, NOR, NAND, XNOR}
    always_comb begin
        w_exp = 6'b000111;
        unique case (r_vec)
            2'b00: w_exp = 6'b000111;
            2'b01: w_exp = 6'b101010;
            2'b10: w_exp = 6'b101010;
            2'b11: w_exp = 6'b110001;
        endcase
    end

    assign w_miss     = (y != w_exp);
    assign w_mask_nxt = w_miss ? (r_mask | (4'b0001 << r_vec)) : r_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == CNT_LAST) w_next = S_CHECK;
            S_CHECK:  w_next = (r_vec == 2'b11) ? S_DONE : S_SETTLE;
            S_DONE:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec   <= 2'b00;
            r_cnt   <= '0;
            r_mask  <= 4'b0000;
            r_count <= 3'd0;
            r_pass  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec   <= 2'b00;
                        r_cnt   <= '0;
                        r_mask  <= 4'b0000;
                        r_count <= 3'd0;
                        r_pass  <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + CW'(1);
                end
                S_CHECK: begin
                    r_mask <= w_mask_nxt;
                    if (w_miss) r_count <= r_count + 3'd1;
                    // pass must already include the last vector's result
                    if (r_vec == 2'b11) begin
                        r_pass <= (w_mask_nxt == 4'b0000);
                    end else begin
                        r_vec <= r_vec + 2'b01;
                        r_cnt <= '0;
                    end
                end
                S_DONE: begin
                end
            endcase
        end
    end

    assign a          = r_vec[1];
    assign b          = r_vec[0];
    assign pass       = r_pass;
    assign fail_mask  = r_mask;
    assign fail_count = r_count;

endmodule

// File: tb/tb_gates_selftest_seq.sv
// Directed bench for gates_selftest_seq: table of faulty gate models
// plus hand sequences for busy-start, reset, retrigger and SETTLE_CYCLES=1.
module tb_gates_selftest_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] y;
    logic       a, b, busy, done, pass;
    logic [3:0] fail_mask;
    logic [2:0] fail_count;

    logic       start1 = 1'b0;
    logic [5:0] y1;
    logic       a1, b1, busy1, done1, pass1;
    logic [3:0] fail_mask1;
    logic [2:0] fail_count1;

    int total = 0;
    int bad   = 0;
    int fmode = 0;

    always #5 clk = ~clk;

    gates_selftest_seq #(.SETTLE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y(y),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .fail_mask(fail_mask), .fail_count(fail_count)
    );

    gates_selftest_seq #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_mask(fail_mask1), .fail_count(fail_count1)
    );

    // Gate block model with selectable faults
    always_comb begin
        y = {a | b, a & b, a ^ b, ~(a | b), ~(a & b), ~(a ^ b)};
        case (fmode)
            1: y[3] = 1'b0;
            2: y[1] = ~y[1];
            3: y[4] = 1'b1;
            4: y = 6'b000000;
            default: ;
        endcase
    end

    assign y1 = {a1 | b1, a1 & b1, a1 ^ b1, ~(a1 | b1), ~(a1 & b1), ~(a1 ^ b1)};

    typedef struct {
        int         mode;
        logic [3:0] mask;
        logic [2:0] cnt;
        logic       pas;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic run0(input int mode, input logic [3:0] emask,
                        input logic [2:0] ecnt, input logic epass);
        int n;
        int ab_bad;
        fmode = mode;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_clear", int'({pass, fail_mask, fail_count}), 0);
        n = 0;
        ab_bad = 0;
        while (!done && n < 100) begin
            if (!busy) ab_bad++;
            if (int'({a, b}) != n / 5) ab_bad++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("ab_sequence", ab_bad, 0);
        chk("done_cycle", n + 1, 21);
        chk("done_busy", int'(busy), 1);
        chk("pass", int'(pass), int'(epass));
        chk("fail_mask", int'(fail_mask), int'(emask));
        chk("fail_count", int'(fail_count), int'(ecnt));
        @(posedge clk);
        #1;
        chk("done_pulse", int'({done, busy}), 0);
        chk("hold_ab", int'({a, b}), 3);
        chk("hold_pass", int'(pass), int'(epass));
    endtask

    initial begin
        int n;
        int nd;
        int d1;
        int d2;
        tbl[0] = '{mode: 1, mask: 4'b0110, cnt: 3'd2, pas: 1'b0};
        tbl[1] = '{mode: 0, mask: 4'b0000, cnt: 3'd0, pas: 1'b1};
        tbl[2] = '{mode: 2, mask: 4'b1111, cnt: 3'd4, pas: 1'b0};
        tbl[3] = '{mode: 3, mask: 4'b0111, cnt: 3'd3, pas: 1'b0};
        tbl[4] = '{mode: 4, mask: 4'b1111, cnt: 3'd4, pas: 1'b0};

        #1;
        chk("reset_state",
            int'({a, b, busy, done, pass, fail_mask, fail_count}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_no_start", int'({busy, done}), 0);

        for (int i = 0; i < 5; i++) begin
            run0(tbl[i].mode, tbl[i].mask, tbl[i].cnt, tbl[i].pas);
        end

        // start pulses at clock 5 and in the done cycle are ignored
        fmode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nd = 0;
        for (int i = 1; i < 60; i++) begin
            @(posedge clk);
            #1;
            start = (i == 4) || done;
            if (done) nd++;
        end
        start = 1'b0;
        chk("busy_start_dones", nd, 1);
        chk("busy_start_idle", int'(busy), 0);

        // reset in the middle of a run
        fmode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ab", int'({a, b}), 0);
        chk("rst_mid_busy", int'({busy, done}), 0);
        chk("rst_mid_res", int'({pass, fail_mask, fail_count}), 0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("rst_no_done", nd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run0(0, 4'b0000, 3'd0, 1'b1);

        // start held high retriggers every 22 clocks
        fmode = 0;
        d1 = -1;
        d2 = -1;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        start = 1'b0;
        chk("retrigger_gap", d2 - d1, 22);
        n = 0;
        while (busy && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("retrigger_idle", int'(busy), 0);

        // SETTLE_CYCLES=1 instance
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        n = 0;
        nd = 0;
        while (!done1 && n < 50) begin
            if (int'({a1, b1}) != n / 2) nd++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("s1_ab_sequence", nd, 0);
        chk("s1_done_cycle", n + 1, 9);
        chk("s1_pass", int'({pass1, fail_mask1, fail_count1}), 128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
